// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and helpers for the UART transmit framer.
//   tx_state_e : framer FSM states
//   parity_e   : encoding of the parity_mode input (2'b11 also means no parity)
//   idx_width  : width of the data-bit index for a given data width
//   parity_on  : true when a parity_mode value requests a parity bit
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIGN  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_ODD  = 2'b01,
        PAR_EVEN = 2'b10
    } parity_e;

    function automatic int idx_width(input int data_width);
        return $clog2(data_width);
    endfunction

    // 2'b11 is an alias for "no parity", so only the two explicit modes count.
    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_ODD) || (mode == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_tx_tick.sv
// -----------------------------------------------------------------------------
// uart_tx_tick
// Converts the level baud clock into one-clk-wide bit ticks on its rising edge.
// Ports:
//   clk      in  system clock
//   rst      in  asynchronous active-high reset
//   baud_clk in  level baud clock, synchronous to clk
//   tick     out high for one clk cycle per baud_clk rising edge
// -----------------------------------------------------------------------------
module uart_tx_tick
    import uart_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic baud_clk,
    output logic tick
);

    logic baud_q;
    logic baud_d;

    always_comb begin
        baud_d = baud_clk;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_d;
        end
    end

    // baud_clk is already synchronous to clk, so the live level against its
    // one-cycle-old copy gives the rising edge without extra latency.
    assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
// UART transmit framer: accepts one word per valid/ready handshake and sends
// start bit, DATA_WIDTH data bits LSB first, optional parity, 1 or 2 stop bits.
// Every bit lasts one baud_clk period; all state runs on clk.
// Parameters:
//   DATA_WIDTH   data bits per frame (5..9)
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   baud_clk     in   level baud clock from the TX baud generator
//   tx_data      in   word to send, sampled on handshake
//   tx_valid     in   a word is offered
//   tx_ready     out  framer is idle and can accept a word
//   parity_mode  in   00 none, 01 odd, 10 even, 11 none; sampled on handshake
//   two_stop     in   0 one stop bit, 1 two stop bits; sampled on handshake
//   tx           out  serial line, idles high
//   busy         out  frame accepted and not yet completed
//   done         out  one-cycle pulse when the last stop bit ends
// -----------------------------------------------------------------------------
module uart_tx_frame
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_clk,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [1:0]            parity_mode,
    input  logic                  two_stop,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    localparam int              IDX_W    = idx_width(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    logic tick;

    uart_tx_tick u_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    tx_state_e             state_q,    state_d;
    logic [DATA_WIDTH-1:0] shreg_q,    shreg_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic                  par_acc_q,  par_acc_d;
    logic [1:0]            par_mode_q, par_mode_d;
    logic                  two_stop_q, two_stop_d;
    logic                  stop_cnt_q, stop_cnt_d;
    logic                  tx_q,       tx_d;
    logic                  ready_q,    ready_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;

    logic accept;

    // ready_q is only high in IDLE, so this also ignores tx_valid while busy.
    assign accept = tx_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        idx_d      = idx_q;
        par_acc_d  = par_acc_q;
        par_mode_d = par_mode_q;
        two_stop_d = two_stop_q;
        stop_cnt_d = stop_cnt_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A tick coinciding with the handshake is deliberately not
                // used: ALIGN waits for the next one so the start bit is full.
                if (accept) begin
                    shreg_d    = tx_data;
                    par_mode_d = parity_mode;
                    two_stop_d = two_stop;
                    par_acc_d  = 1'b0;
                    idx_d      = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (tick) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    // Parity is accumulated from the bits as they leave, so
                    // no separate copy of the word is kept.
                    par_acc_d = par_acc_q ^ shreg_q[0];
                    shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                    if (idx_q == LAST_IDX) begin
                        idx_d      = '0;
                        stop_cnt_d = 1'b0;
                        state_d    = parity_on(par_mode_q) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    if (two_stop_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered tx
    // changes on the very edge that consumes the tick.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            PARITY:  tx_d = (par_mode_q == PAR_EVEN) ? par_acc_d : ~par_acc_d;
            default: tx_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            par_acc_q  <= 1'b0;
            par_mode_q <= 2'b00;
            two_stop_q <= 1'b0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            par_acc_q  <= par_acc_d;
            par_mode_q <= par_mode_d;
            two_stop_q <= two_stop_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame with DATA_WIDTH = 8 and a 32-cycle baud_clk.
// Expected bit sequences are written MSB-first in transmit order.
// -----------------------------------------------------------------------------
module tb_uart_tx_frame;

    localparam int DW = 8;

    logic          clk         = 1'b0;
    logic          rst         = 1'b1;
    logic          baud_clk    = 1'b0;
    logic [DW-1:0] tx_data     = '0;
    logic          tx_valid    = 1'b0;
    logic [1:0]    parity_mode = 2'b00;
    logic          two_stop    = 1'b0;
    logic          tx;
    logic          tx_ready;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;
    int tick_cnt = 0;
    int bcnt     = 0;
    logic baud_prev = 1'b0;

    uart_tx_frame #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_clk    (baud_clk),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Free-running baud generator: 16 cycles high, 16 low.
    always @(posedge clk) begin
        if (bcnt == 15) begin
            bcnt     <= 0;
            baud_clk <= ~baud_clk;
        end else begin
            bcnt <= bcnt + 1;
        end
    end

    // Count the clk edges on which a bit tick is due (baud_clk newly high).
    always @(posedge clk) begin
        baud_prev <= baud_clk;
        if (baud_clk && !baud_prev) tick_cnt <= tick_cnt + 1;
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns at the first negedge after the next tick edge.
    task automatic wait_tick();
        int   n   = tick_cnt;
        logic got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (tick_cnt != n) got = 1'b1;
        end
        chk("tick_seen", 16'(got), 16'd1);
    endtask

    task automatic start_frame(input logic [DW-1:0] d, input logic [1:0] pm,
                               input logic ts, input logic hold);
        tx_data     = d;
        parity_mode = pm;
        two_stop    = ts;
        tx_valid    = 1'b1;
        @(negedge clk);
        chk($sformatf("accept_ready %02h", d), 16'(tx_ready), 16'd0);
        chk($sformatf("accept_busy %02h", d), 16'(busy), 16'd1);
        chk($sformatf("align_tx %02h", d), 16'(tx), 16'd1);
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [15:0] exp, input int n);
        int c0 = done_cnt;
        for (int i = 0; i < n; i++) begin
            wait_tick();
            chk($sformatf("%s bit%0d", name, i), 16'(tx), 16'(exp[n-1-i]));
            chk($sformatf("%s done_low%0d", name, i), 16'(done), 16'd0);
            chk($sformatf("%s busy%0d", name, i), 16'(busy), 16'd1);
        end
        wait_tick();
        chk({name, " done_pulse"}, 16'(done), 16'd1);
        chk({name, " end_ready"}, 16'(tx_ready), 16'd1);
        chk({name, " end_busy"}, 16'(busy), 16'd0);
        chk({name, " end_tx"}, 16'(tx), 16'd1);
        @(negedge clk);
        chk({name, " done_one_cycle"}, 16'(done), 16'd0);
        chk({name, " done_count"}, 16'(done_cnt), 16'(c0 + 1));
    endtask

    initial begin
        int c0;

        // Reset held while baud_clk keeps toggling.
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            repeat (8) @(negedge clk);
            chk("rst_tx", 16'(tx), 16'd1);
            chk("rst_ready", 16'(tx_ready), 16'd1);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_done", 16'(done), 16'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);

        start_frame(8'hA5, 2'b00, 1'b0, 1'b0);
        check_frame("a5_none", 16'b0101001011, 10);

        start_frame(8'hA5, 2'b01, 1'b0, 1'b0);
        check_frame("a5_odd", 16'b01010010111, 11);

        start_frame(8'hA5, 2'b10, 1'b0, 1'b0);
        check_frame("a5_even", 16'b01010010101, 11);

        start_frame(8'h07, 2'b10, 1'b0, 1'b0);
        check_frame("07_even", 16'b01110000011, 11);

        start_frame(8'h07, 2'b11, 1'b0, 1'b0);
        check_frame("07_mode11", 16'b0111000001, 10);

        start_frame(8'h00, 2'b00, 1'b1, 1'b0);
        check_frame("00_two_stop", 16'b00000000011, 11);

        // Back-to-back with tx_valid held and inputs changed mid-frame.
        start_frame(8'h55, 2'b10, 1'b0, 1'b1);
        tx_data     = 8'hAA;
        parity_mode = 2'b00;
        two_stop    = 1'b0;
        check_frame("b2b_55", 16'b01010101001, 11);
        chk("b2b_accept_ready", 16'(tx_ready), 16'd0);
        chk("b2b_accept_busy", 16'(busy), 16'd1);
        chk("b2b_gap_tx", 16'(tx), 16'd1);
        tx_valid = 1'b0;
        check_frame("b2b_aa", 16'b0010101011, 10);

        // Reset during data bit 3.
        start_frame(8'h81, 2'b00, 1'b0, 1'b0);
        c0 = done_cnt;
        for (int i = 0; i < 5; i++) begin
            logic [4:0] pre;
            pre = 5'b01000;
            wait_tick();
            chk($sformatf("pre_rst bit%0d", i), 16'(tx), 16'(pre[4-i]));
        end
        #2 rst = 1'b1;
        #1;
        chk("midrst_tx", 16'(tx), 16'd1);
        chk("midrst_busy", 16'(busy), 16'd0);
        chk("midrst_ready", 16'(tx_ready), 16'd1);
        chk("midrst_done", 16'(done), 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrst_no_done", 16'(done_cnt), 16'(c0));
        chk("midrst_idle_tx", 16'(tx), 16'd1);

        start_frame(8'h3C, 2'b00, 1'b0, 1'b0);
        check_frame("3c_after_rst", 16'b0001111001, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
